// File: rtl/expr_result_pkg.sv
// expr_result_pkg: field layout of the 90-bit expression-result word and shared types
package expr_result_pkg;
    localparam int WORD_W     = 90;
    localparam int NUM_FIELDS = 18;
    localparam int OUT_W      = 6;
    localparam int IDX_W      = 5;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic int fld_w(input int k);
        return 4 + k % 3;
    endfunction

    function automatic bit fld_signed(input int k);
        return ((k / 3) % 2) == 1;
    endfunction

    // Groups of three fields (4+5+6 bits) span 15 bits, packed MSB-first
    function automatic int fld_lsb(input int k);
        int g = k / 3;
        int j = k % 3;
        return WORD_W - 15 * g - (4 * j + j * (j - 1) / 2) - fld_w(k);
    endfunction
endpackage

// File: rtl/expr_field_extract.sv
// expr_field_extract: selects field idx of a result word and extends it to OUT_W bits
module expr_field_extract
    import expr_result_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [OUT_W-1:0]  data,
    output logic              sgn,
    output logic              last
);
    logic [OUT_W-1:0]      ext [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] smask;

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_fld
        localparam int W = fld_w(g);
        localparam int L = fld_lsb(g);
        localparam bit S = fld_signed(g);
        logic [W-1:0] f;
        assign f        = word[L +: W];
        assign smask[g] = S;
        if (S) begin : g_s
            assign ext[g] = OUT_W'($signed(f));
        end else begin : g_u
            assign ext[g] = OUT_W'(f);
        end
    end

    assign data = (idx < IDX_W'(NUM_FIELDS)) ? ext[idx] : '0;
    assign sgn  = (idx < IDX_W'(NUM_FIELDS)) ? smask[idx] : 1'b0;
    assign last = idx == IDX_W'(NUM_FIELDS - 1);
endmodule

// File: rtl/expr_result_unpacker.sv
// expr_result_unpacker: accepts packed result words and streams their 18 extended fields
// with index, signedness, last flag and a per-word XOR signature.
module expr_result_unpacker
    import expr_result_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_signed,
    output logic              out_last,
    output logic [OUT_W-1:0]  out_sig
);
    state_t            state, state_n;
    logic [WORD_W-1:0] act_word, act_n, pend_word, pend_n;
    logic              pend_full, pend_full_n, in_ready_q;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [OUT_W-1:0]  sig, sig_n, fd;
    logic              fs, fl, xfer, take, retire, load_new, load_pend;

    expr_field_extract u_ext (
        .word (act_word),
        .idx  (idx),
        .data (fd),
        .sgn  (fs),
        .last (fl)
    );

    assign in_ready   = in_ready_q;
    assign out_valid  = state == EMIT;
    assign xfer       = in_valid & in_ready_q;
    assign take       = out_valid & out_ready;
    assign retire     = take & fl;
    assign load_pend  = retire & pend_full;
    // A new word bypasses PENDING only when ACTIVE is free and PENDING holds nothing older
    assign load_new   = xfer & (!out_valid | (retire & !pend_full));
    assign out_data   = out_valid ? fd : '0;
    assign out_idx    = out_valid ? idx : '0;
    assign out_signed = out_valid & fs;
    assign out_last   = out_valid & fl;
    assign out_sig    = (out_valid & fl) ? (sig ^ fd) : '0;

    always_comb begin
        state_n     = state;
        act_n       = act_word;
        pend_n      = pend_word;
        pend_full_n = pend_full;
        idx_n       = idx;
        sig_n       = sig;
        if (take) begin
            idx_n = idx + IDX_W'(1);
            sig_n = sig ^ fd;
        end
        if (load_pend) begin
            act_n       = pend_word;
            pend_full_n = 1'b0;
        end else if (load_new) begin
            act_n = in_data;
        end
        if (xfer & !load_new) begin
            pend_n      = in_data;
            pend_full_n = 1'b1;
        end
        if (load_pend | load_new) begin
            state_n = EMIT;
            idx_n   = '0;
            sig_n   = '0;
        end else if (retire) begin
            state_n = IDLE;
            idx_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            act_word   <= '0;
            pend_word  <= '0;
            pend_full  <= 1'b0;
            in_ready_q <= 1'b0;
            idx        <= '0;
            sig        <= '0;
        end else begin
            state      <= state_n;
            act_word   <= act_n;
            pend_word  <= pend_n;
            pend_full  <= pend_full_n;
            in_ready_q <= !pend_full_n;
            idx        <= idx_n;
            sig        <= sig_n;
        end
    end
endmodule

// File: tb/tb_expr_result_unpacker.sv
// tb_expr_result_unpacker: directed and random words checked by a queue-based scoreboard
module tb_expr_result_unpacker;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [89:0] in_data = '0;
    logic        in_ready, out_valid, out_signed, out_last;
    logic [5:0]  out_data, out_sig;
    logic [4:0]  out_idx;

    typedef struct packed {
        logic [5:0] d;
        logic [4:0] i;
        logic       s;
        logic       l;
        logic [5:0] g;
    } exp_t;

    exp_t exp_q[$];
    int   take_cyc[$];
    int   errors = 0, checks = 0, cyc = 0;
    bit   rnd_rdy = 0, rdy_set = 0;
    logic [17:0] smask = 18'b111000111000111000;
    logic [5:0]  ao [6] = '{6'h0F, 6'h1F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};

    expr_result_unpacker dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_signed(out_signed), .out_last(out_last), .out_sig(out_sig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #2;
        out_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : rdy_set;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Monitor: every presented field must match the queue head; pop on take
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_field: idx=%0d data=%h with nothing expected", out_idx, out_data);
            end else begin
                if (out_data !== exp_q[0].d || out_idx !== exp_q[0].i || out_signed !== exp_q[0].s ||
                    out_last !== exp_q[0].l || (exp_q[0].l && out_sig !== exp_q[0].g)) begin
                    errors++;
                    $display("FAIL field: got d=%h i=%0d s=%b l=%b sig=%h, expected d=%h i=%0d s=%b l=%b sig=%h",
                             out_data, out_idx, out_signed, out_last, out_sig,
                             exp_q[0].d, exp_q[0].i, exp_q[0].s, exp_q[0].l, exp_q[0].g);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    take_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [5:0] d, input int i, input logic l, input logic [5:0] g);
        exp_t e;
        e.d = d; e.i = 5'(i); e.s = smask[i]; e.l = l; e.g = g;
        exp_q.push_back(e);
    endtask

    // Reference unpacker: walks a bit pointer down from the MSB
    function automatic void push_word(input logic [89:0] w);
        exp_t e [18];
        int pos = 89;
        logic [5:0] s = '0;
        for (int k = 0; k < 18; k++) begin
            int wd = 4 + k % 3;
            logic [5:0] v = '0;
            for (int b = 0; b < wd; b++) v[b] = w[pos - wd + 1 + b];
            if (((k / 3) % 2) == 1 && v[wd - 1])
                for (int b = wd; b < 6; b++) v[b] = 1'b1;
            s ^= v;
            pos -= wd;
            e[k].d = v; e[k].i = 5'(k); e[k].s = ((k / 3) % 2) == 1; e[k].l = (k == 17); e[k].g = '0;
        end
        e[17].g = s;
        for (int k = 0; k < 18; k++) exp_q.push_back(e[k]);
    endfunction

    task automatic send(input logic [89:0] w, output int acc, output int waited);
        waited = 0;
        in_data = w;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
        end
        acc = cyc;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int i);
        int n = 0;
        while (!(out_valid && out_idx == 5'(i)) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("wait_idx", {out_valid, 3'b0, out_idx}, {1'b1, 3'b0, 5'(i)});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_signed"}, out_signed, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_sig"}, out_sig, 0);
    endtask

    initial begin
        int a1, a2, a3, w1, w2, w3, base, n, vcount;
        logic [95:0] r;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        rst_n = 1;
        @(posedge clk);
        #1 chk("in_ready_after_reset", in_ready, 1);
        rdy_set = 1;

        // All-ones word
        for (int k = 0; k < 18; k++) push_exp(ao[k % 6], k, k == 17, 6'h10);
        send('1, a1, w1);
        drain();

        // Single-bit words: unsigned MSB of field 0, signed MSB of field 3
        for (int k = 0; k < 18; k++) push_exp(k == 0 ? 6'h08 : 6'h00, k, k == 17, 6'h08);
        send(90'd1 << 89, a1, w1);
        drain();
        for (int k = 0; k < 18; k++) push_exp(k == 3 ? 6'h38 : 6'h00, k, k == 17, 6'h38);
        send(90'd1 << 74, a1, w1);
        drain();

        // Backpressure for 5 cycles at idx 7
        push_word(90'h2A5_F0C3_1E96_7B4D_0815_C3A9);
        send(90'h2A5_F0C3_1E96_7B4D_0815_C3A9, a1, w1);
        wait_idx(7);
        rdy_set = 0;
        repeat (5) @(posedge clk);
        #1 rdy_set = 1;
        drain();
        n = take_cyc.size();
        chk("bp_hold_gap", take_cyc[n-11] - take_cyc[n-12], 6);
        chk("bp_tail_span", take_cyc[n-1] - take_cyc[n-11], 10);

        // Three words back-to-back
        base = take_cyc.size();
        push_word(90'h3FF_0000_FFFF_0000_FFFF_0001);
        push_word(90'h155_5555_5555_5555_5555_5555);
        push_word(90'h0AA_AAAA_AAAA_AAAA_AAAA_AAAA);
        send(90'h3FF_0000_FFFF_0000_FFFF_0001, a1, w1);
        send(90'h155_5555_5555_5555_5555_5555, a2, w2);
        send(90'h0AA_AAAA_AAAA_AAAA_AAAA_AAAA, a3, w3);
        drain();
        n = take_cyc.size();
        chk("b2b_count", n - base, 54);
        chk("b2b_span", take_cyc[n-1] - take_cyc[base], 53);
        chk("b2b_second_wait", w2, 0);
        chk("b2b_third_stall", w3, 17);
        chk("b2b_third_accept", a3, take_cyc[base+17] + 1);

        // Reset at idx 9 with PENDING full
        push_word(90'h123_4567_89AB_CDEF_0123_4567);
        push_word(90'h3C3_C3C3_C3C3_C3C3_C3C3_C3C3);
        send(90'h123_4567_89AB_CDEF_0123_4567, a1, w1);
        send(90'h3C3_C3C3_C3C3_C3C3_C3C3_C3C3, a2, w2);
        wait_idx(9);
        rst_n = 0;
        #1 chk_reset_outputs("midword_reset");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1;
        vcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("no_emit_after_reset", vcount, 0);
        @(posedge clk);
        #1 chk("in_ready_after_midreset", in_ready, 1);
        push_word(90'h0F0_F0F0_F0F0_F0F0_F0F0_F0F0);
        send(90'h0F0_F0F0_F0F0_F0F0_F0F0_F0F0, a1, w1);
        drain();

        // Random words with random out_ready
        rnd_rdy = 1;
        for (int t = 0; t < 12; t++) begin
            r = {$urandom(), $urandom(), $urandom()};
            push_word(r[89:0]);
            send(r[89:0], a1, w1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        rnd_rdy = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
